// File: rtl/instr_pkg.sv
// instr_pkg: instruction field positions, F_Code classes and sequencer states
package instr_pkg;
    localparam int RI_BIT   = 31;
    localparam int RS_HI    = 30;
    localparam int RS_LO    = 25;
    localparam int RD_HI    = 24;
    localparam int RD_LO    = 19;
    localparam int MODE_BIT = 18;
    localparam int FC_HI    = 17;
    localparam int FC_LO    = 15;
    localparam int RT_HI    = 14;
    localparam int RT_LO    = 9;
    localparam int IMM_HI   = 14;
    localparam int IMM_LO   = 0;
    localparam logic [2:0] FC_REGWR = 3'b100;
    localparam logic [2:0] FC_STORE = 3'b110;
    localparam logic [2:0] FC_HALT  = 3'b111;
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
endpackage

// File: rtl/instr_field_split.sv
// instr_field_split: combinational split of an instruction word into decode fields and class flags
module instr_field_split
    import instr_pkg::*;
(
    input  logic [31:0] ir,
    output logic        ri,
    output logic [5:0]  rs,
    output logic [5:0]  rd,
    output logic        mode,
    output logic [2:0]  fcode,
    output logic [5:0]  rt,
    output logic [14:0] imm,
    output logic        is_regwr,
    output logic        is_store,
    output logic        is_halt
);
    assign ri       = ir[RI_BIT];
    assign rs       = ir[RS_HI:RS_LO];
    assign rd       = ir[RD_HI:RD_LO];
    assign mode     = ir[MODE_BIT];
    assign fcode    = ir[FC_HI:FC_LO];
    assign rt       = ir[RT_HI:RT_LO];
    assign imm      = ir[IMM_HI:IMM_LO];
    assign is_regwr = fcode == FC_REGWR;
    // I-type store encoding falls through as a NOP
    assign is_store = !ri && fcode == FC_STORE;
    assign is_halt  = ri && fcode == FC_HALT;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/exec/mem/wb controller owning the PC and retire counter
module instr_sequencer
    import instr_pkg::*;
#(
    parameter int PC_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             ir_ri,
    output logic [5:0]       ir_rs,
    output logic [5:0]       ir_rd,
    output logic             ir_mode,
    output logic [2:0]       ir_fcode,
    output logic [5:0]       ir_rt,
    output logic [14:0]      ir_imm,
    output logic             alu_en,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             reg_we,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);
    state_t          state, state_n;
    logic [31:0]     ir;
    logic [PC_W-1:0] pc;
    logic            is_regwr, is_store, is_halt, retire;

    instr_field_split u_split (
        .ir       (ir),
        .ri       (ir_ri),
        .rs       (ir_rs),
        .rd       (ir_rd),
        .mode     (ir_mode),
        .fcode    (ir_fcode),
        .rt       (ir_rt),
        .imm      (ir_imm),
        .is_regwr (is_regwr),
        .is_store (is_store),
        .is_halt  (is_halt)
    );

    always_comb begin
        state_n   = state;
        imem_req  = state == FETCH;
        imem_addr = pc;
        alu_en    = state == EXEC;
        dmem_req  = state == MEM;
        dmem_we   = state == MEM;
        reg_we    = state == WB;
        busy      = !(state inside {IDLE, HALT});
        halted    = state == HALT;
        case (state)
            IDLE:    state_n = start ? FETCH : IDLE;
            FETCH:   state_n = imem_ready ? DECODE : FETCH;
            DECODE:  state_n = is_halt ? HALT : EXEC;
            EXEC:    state_n = is_regwr ? WB : is_store ? MEM : FETCH;
            MEM:     state_n = dmem_ready ? FETCH : MEM;
            WB:      state_n = FETCH;
            default: state_n = state;
        endcase
    end

    // an instruction retires on any return to FETCH from the execute phases
    assign retire = state_n == FETCH && state inside {EXEC, MEM, WB};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ir          <= '0;
            pc          <= '0;
            instr_count <= '0;
        end else begin
            state <= state_n;
            if (imem_req && imem_ready) ir <= imem_rdata;
            if (retire) begin
                pc          <= pc + PC_W'(4);
                instr_count <= instr_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized transaction-level check of instr_sequencer against a spec model
module tb_instr_sequencer;
    logic        clk = 0, rst = 1, start = 0;
    logic        imem_ready = 0, dmem_ready = 0;
    logic [31:0] imem_rdata = 0;
    logic        imem_req, ir_ri, ir_mode, alu_en, dmem_req, dmem_we, reg_we, busy, halted;
    logic [15:0] imem_addr, instr_count;
    logic [5:0]  ir_rs, ir_rd, ir_rt;
    logic [2:0]  ir_fcode;
    logic [14:0] ir_imm;

    logic        rst2 = 1, start2 = 0;
    logic        s_req, s_ri, s_mode, s_alu, s_dreq, s_dwe, s_rwe, s_busy, s_halt;
    logic [3:0]  s_addr;
    logic [15:0] s_cnt;
    logic [5:0]  s_rs, s_rd, s_rt;
    logic [2:0]  s_fc;
    logic [14:0] s_imm;

    int n_cmp = 0, n_err = 0;
    logic [15:0] mpc, mcount;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .ir_ri(ir_ri), .ir_rs(ir_rs),
        .ir_rd(ir_rd), .ir_mode(ir_mode), .ir_fcode(ir_fcode), .ir_rt(ir_rt), .ir_imm(ir_imm),
        .alu_en(alu_en), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .reg_we(reg_we), .busy(busy), .halted(halted), .instr_count(instr_count)
    );

    instr_sequencer #(.PC_W(4)) dut_small (
        .clk(clk), .rst(rst2), .start(start2), .imem_req(s_req), .imem_addr(s_addr),
        .imem_ready(1'b1), .imem_rdata(32'h0), .ir_ri(s_ri), .ir_rs(s_rs),
        .ir_rd(s_rd), .ir_mode(s_mode), .ir_fcode(s_fc), .ir_rt(s_rt), .ir_imm(s_imm),
        .alu_en(s_alu), .dmem_req(s_dreq), .dmem_we(s_dwe), .dmem_ready(1'b0),
        .reg_we(s_rwe), .busy(s_busy), .halted(s_halt), .instr_count(s_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic noise();
        imem_ready = 1'($urandom);
        imem_rdata = $urandom;
        dmem_ready = 1'($urandom);
        start      = 1'($urandom);
    endtask

    task automatic start_up();
        rst = 1;
        start = 0;
        imem_ready = 0;
        dmem_ready = 0;
        @(negedge clk);
        check("rst_imem_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_count", instr_count, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_fcode", ir_fcode, 0);
        check("rst_imm", ir_imm, 0);
        rst = 0;
        start = 1;
        @(negedge clk);
        mpc = 0;
        mcount = 0;
    endtask

    function automatic logic [31:0] rand_word();
        logic       ri = 1'($urandom);
        logic [2:0] fc = 3'($urandom_range(0, 7));
        logic [5:0] rs = 6'($urandom), rd = 6'($urandom);
        logic       md = 1'($urandom);
        logic [14:0] lo = 15'($urandom);
        if (ri && fc == 3'b111) fc = 3'b000;
        return {ri, rs, rd, md, fc, lo};
    endfunction

    task automatic check_fields(input string ph, input logic [31:0] w);
        check({ph, "_ri"}, ir_ri, w[31]);
        check({ph, "_rs"}, ir_rs, w[30:25]);
        check({ph, "_rd"}, ir_rd, w[24:19]);
        check({ph, "_mode"}, ir_mode, w[18]);
        check({ph, "_fcode"}, ir_fcode, w[17:15]);
        check({ph, "_rt"}, ir_rt, w[14:9]);
        check({ph, "_imm"}, ir_imm, w[14:0]);
    endtask

    // one instruction from fetch to retire; abort>=0 resets during that MEM wait cycle
    task automatic do_instr(input logic [31:0] w, input int idly, input int ddly, input int abort);
        logic halt  = w[31] && w[17:15] == 3'b111;
        logic store = !w[31] && w[17:15] == 3'b110;
        logic regwr = w[17:15] == 3'b100;
        for (int i = 0; i <= idly; i++) begin
            noise();
            imem_ready = (i == idly);
            if (i == idly) imem_rdata = w;
            check("f_req", imem_req, 1);
            check("f_addr", imem_addr, mpc);
            check("f_count", instr_count, mcount);
            check("f_busy", busy, 1);
            check("f_alu", alu_en, 0);
            @(negedge clk);
        end
        noise();
        check_fields("dec", w);
        check("d_req", imem_req, 0);
        check("d_alu", alu_en, 0);
        check("d_busy", busy, 1);
        @(negedge clk);
        if (halt) begin
            for (int i = 0; i < 4; i++) begin
                noise();
                check("h_halted", halted, 1);
                check("h_busy", busy, 0);
                check("h_req", imem_req, 0);
                check("h_addr", imem_addr, mpc);
                check("h_count", instr_count, mcount);
                @(negedge clk);
            end
            return;
        end
        noise();
        check("e_alu", alu_en, 1);
        check("e_reg_we", reg_we, 0);
        check("e_dreq", dmem_req, 0);
        @(negedge clk);
        if (store) begin
            for (int i = 0; i <= ddly; i++) begin
                noise();
                dmem_ready = (i == ddly);
                check("m_dreq", dmem_req, 1);
                check("m_dwe", dmem_we, 1);
                check("m_alu", alu_en, 0);
                check("m_reg_we", reg_we, 0);
                if (i == abort) begin
                    rst = 1;
                    #1;
                    check("abort_dreq", dmem_req, 0);
                    check("abort_dwe", dmem_we, 0);
                    check("abort_addr", imem_addr, 0);
                    check("abort_count", instr_count, 0);
                    check("abort_busy", busy, 0);
                    return;
                end
                @(negedge clk);
            end
            check_fields("mem_end", w);
        end else if (regwr) begin
            noise();
            check("w_reg_we", reg_we, 1);
            check("w_alu", alu_en, 0);
            check("w_dreq", dmem_req, 0);
            check_fields("wb", w);
            @(negedge clk);
        end
        mpc += 16'd4;
        mcount += 16'd1;
    endtask

    initial begin
        start_up();
        do_instr(32'h00020000, 0, 0, -1);
        do_instr(32'h00030000, 0, 3, -1);
        do_instr(32'h80030005, 0, 0, -1);
        do_instr(32'h80038000, 0, 0, -1);
        start_up();
        for (int k = 0; k < 60; k++)
            do_instr(rand_word(), $urandom_range(0, 2), $urandom_range(0, 3), -1);
        do_instr(rand_word() & 32'h7FFC7FFF | 32'h00030000, 1, 5, 2);
        start_up();
        for (int k = 0; k < 10; k++)
            do_instr(rand_word(), $urandom_range(0, 2), $urandom_range(0, 3), -1);
        do_instr(rand_word() | 32'h80038000, 1, 0, -1);
        rst2 = 0;
        start2 = 1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("small_req", s_req, 1);
            check("small_addr", s_addr, (4 * k) % 16);
            repeat (3) @(negedge clk);
        end
        check("small_count", s_cnt, 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle control sequencer for the 32-bit R/I-type core. It fetches an instruction over a ready handshake and latches it into an instruction register. It then exposes the registered decode fields and steps the datapath through DECODE, EXEC, MEM and WB, issuing one-cycle enables and a data-memory handshake. It sits between instruction memory and the register file/ALU/data memory and owns the PC.

Parameters:
PC_W, 16, width of PC / imem_addr (byte address, steps by 4)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  level; IDLE->FETCH when high
imem_req  out  1  fetch request, held until accepted
imem_addr  out  PC_W  current PC
imem_ready  in  1  fetch accept; imem_rdata valid same cycle
imem_rdata  in  32  instruction word
ir_ri  out  1  IR[31], 0=R-type, 1=I-type
ir_rs  out  6  IR[30:25]
ir_rd  out  6  IR[24:19]
ir_mode  out  1  IR[18]
ir_fcode  out  3  IR[17:15]
ir_rt  out  6  IR[14:9] (valid for R-type only)
ir_imm  out  15  IR[14:0] (valid for I-type only)
alu_en  out  1  one-cycle pulse in EXEC
dmem_req  out  1  store request, held until accepted
dmem_we  out  1  equals dmem_req (store only)
dmem_ready  in  1  store accept
reg_we  out  1  one-cycle pulse in WB
busy  out  1  high in every state except IDLE and HALT
halted  out  1  high in HALT
instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, immediate): state=IDLE, PC=0, IR=0, instr_count=0. All outputs 0, including imem_req/dmem_req; requests drop in the reset cycle.
- F_Code classes:
  - 3'b100: register write. R- or I-type.
  - 3'b110: store. R-type only; I-type 110 is a NOP.
  - 3'b111 with ri=1: HALT.
  - All others: NOP, executed through EXEC with no side effect.
- IDLE: start=1 -> FETCH next cycle.
- FETCH: imem_req=1, imem_addr=PC.
  - On imem_req&imem_ready, latch imem_rdata into IR -> DECODE.
  - Otherwise stay in FETCH. No timeout.
- DECODE: one cycle; ir_* fields are driven from IR and stay stable until the next fetch accept.
  - HALT class -> HALT. The HALT instruction is not retired and PC does not advance.
  - Otherwise -> EXEC.
- EXEC: alu_en=1 for exactly one cycle.
  - Register write -> WB.
  - Store -> MEM.
  - NOP -> FETCH (retire).
- MEM: dmem_req=dmem_we=1 until dmem_ready; on accept -> FETCH (retire).
- WB: reg_we=1 for one cycle -> FETCH (retire).
- Retire: PC<=PC+4, wrapping modulo 2^PC_W; instr_count<=instr_count+1. Both update on the transition edge into FETCH.
- Zero-wait latency, PC-to-PC:
  - NOP: 3 cycles (FETCH, DECODE, EXEC).
  - Register write: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Store: 4 cycles (FETCH, DECODE, EXEC, MEM).
  - Each wait cycle on imem_ready/dmem_ready adds exactly 1 cycle.
- start is sampled only in IDLE. Deasserting start mid-program has no effect.
- HALT exits only via rst.
- imem_ready/dmem_ready are ignored when the corresponding request is low.
- Simultaneous ready and request in the same cycle counts as accept.
- Reset mid-FETCH or mid-MEM aborts with no retire, and the next fetch is from PC=0.

Decomposition:
- Package instr_pkg:
  - Field bit positions.
  - F_Code constants FC_REGWR=3'b100, FC_STORE=3'b110, FC_HALT=3'b111.
  - State enum {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT}.
- One natural sub-module, instr_field_split: purely combinational IR -> ir_* fields plus class flags (is_regwr, is_store, is_halt). Reusable by the verification model.
- FSM, PC and counter stay in instr_sequencer.

Test Plan:
- Reset, start=1, zero-wait imem returning 0x00020000 (R, F_Code=100) -> imem_addr 0,0,...; reg_we pulses in cycle 4; next imem_addr=4; instr_count=1.
- R-type store 0x00030000 with dmem_ready held low 3 cycles -> dmem_req/dmem_we high 4 cycles, no reg_we; retire after accept; PC=4.
- I-type F_Code=110 (0x80030005) -> treated as NOP: 3-cycle instruction, no dmem_req, no reg_we; ir_imm=5.
- HALT 0x80038000 at PC=8 -> halted=1, busy=0, PC stays 8, instr_count unchanged; start pulses ignored.
- Assert rst during MEM wait -> dmem_req drops immediately; after release with start=1, first imem_addr=0, instr_count=0.
- PC_W=4 with 5 NOPs -> imem_addr sequence 0,4,8,12,0; instr_count=5.
